// File: rtl/multi_rate_addr_seq_pkg.sv
// Shared types and elaboration-time helpers for the multi-rate address sequencer.
//   mode_e    : end-of-range behaviour (encoding 2'b11 is decoded as WRAP by the top)
//   state_e   : run/pause state
//   period_of : clk cycles per address step at a given speed level
//   cnt_w_of  : width of the rate counter (covers the slowest level)
package mrseq_pkg;

  typedef enum logic [1:0] {
    WRAP   = 2'b00,
    STOP   = 2'b01,
    BOUNCE = 2'b10
  } mode_e;

  typedef enum logic {
    RUN    = 1'b0,
    PAUSED = 1'b1
  } state_e;

  // Levels below the default slow down by 2^shift per step, levels above speed
  // up by the same factor, never dropping below one cycle per step.
  function automatic longint unsigned period_of(input int unsigned lvl,
                                                input int unsigned dflt,
                                                input int unsigned base,
                                                input int unsigned shift);
    longint unsigned p;
    if (lvl <= dflt) begin
      p = 64'(base) << (shift * (dflt - lvl));
    end else begin
      p = 64'(base) >> (shift * (lvl - dflt));
      if (p == 64'd0) p = 64'd1;
    end
    return p;
  endfunction

  // Level 0 is always the slowest, so its period sizes the counter.
  function automatic int unsigned cnt_w_of(input int unsigned dflt,
                                           input int unsigned base,
                                           input int unsigned shift);
    longint unsigned pmax;
    int unsigned     w;
    pmax = period_of(0, dflt, base, shift);
    w    = $clog2(pmax);
    return (w == 0) ? 1 : w;
  endfunction

endpackage

// File: rtl/multi_rate_addr_seq_if.sv
// Control/status bundle of the multi-rate address sequencer.
//   master : drives speed_up, speed_down, pause, dir, mode, load, load_addr;
//            observes address, step, level, paused, at_end
//   slave  : the sequencer side (mirror of master)
interface multi_rate_addr_seq_if #(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned LVL_W  = 2
);
  logic              speed_up;
  logic              speed_down;
  logic              pause;
  logic              dir;
  logic [1:0]        mode;
  logic              load;
  logic [ADDR_W-1:0] load_addr;
  logic [ADDR_W-1:0] address;
  logic              step;
  logic [LVL_W-1:0]  level;
  logic              paused;
  logic              at_end;

  modport master (
    output speed_up, speed_down, pause, dir, mode, load, load_addr,
    input  address, step, level, paused, at_end
  );

  modport slave (
    input  speed_up, speed_down, pause, dir, mode, load, load_addr,
    output address, step, level, paused, at_end
  );
endinterface

// File: rtl/multi_rate_addr_seq_rate_tick_gen.sv
// Programmable rate divider: counts clk cycles and fires tick_c on the last
// cycle of the period selected by level.
//   clk, Rst_n : clock, synchronous active-low reset
//   level      : speed level selecting the period
//   clear      : restart the count at 0 (wins over hold)
//   hold       : freeze the count
//   tick_c     : combinational, high on the cycle the count wraps
module rate_tick_gen
  import mrseq_pkg::*;
#(
  parameter int unsigned LEVELS        = 4,
  parameter int unsigned DEFAULT_LEVEL = 1,
  parameter int unsigned BASE_PERIOD   = 100_000_000,
  parameter int unsigned SHIFT         = 2,
  parameter int unsigned LVL_W         = 2
) (
  input  logic             clk,
  input  logic             Rst_n,
  input  logic [LVL_W-1:0] level,
  input  logic             clear,
  input  logic             hold,
  output logic             tick_c
);

  localparam int unsigned CNT_W = cnt_w_of(DEFAULT_LEVEL, BASE_PERIOD, SHIFT);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] last [LEVELS];

  // Constant table of terminal counts (period - 1) per level.
  for (genvar g = 0; g < int'(LEVELS); g++) begin : g_tab
    assign last[g] = CNT_W'(period_of(g, DEFAULT_LEVEL, BASE_PERIOD, SHIFT) - 64'd1);
  end

  assign tick_c = !clear && !hold && (cnt_q == last[level]);

  // Rate counter.
  always_ff @(posedge clk) begin
    if (!Rst_n) begin
      cnt_q <= '0;
    end else if (clear) begin
      cnt_q <= '0;
    end else if (!hold) begin
      cnt_q <= tick_c ? '0 : cnt_q + CNT_W'(1);
    end
  end

endmodule

// File: rtl/multi_rate_addr_seq.sv
// Multi-rate address sequencer: steps an address once per tick of a
// level-selected rate divider, with pause, direction, wrap/stop/bounce end
// handling and synchronous load.
//   clk, Rst_n : clock, synchronous active-low reset
//   bus        : slave side of multi_rate_addr_seq_if
//                in : speed_up, speed_down, pause, dir, mode, load, load_addr
//                out: address, step, level, paused, at_end (all registered)
module multi_rate_addr_seq
  import mrseq_pkg::*;
#(
  parameter int unsigned ADDR_W        = 8,
  parameter int unsigned LEVELS        = 4,
  parameter int unsigned DEFAULT_LEVEL = 1,
  parameter int unsigned BASE_PERIOD   = 100_000_000,
  parameter int unsigned SHIFT         = 2,
  parameter int unsigned ADDR_MIN      = 0,
  parameter int unsigned ADDR_MAX      = (1 << ADDR_W) - 1
) (
  input  logic                  clk,
  input  logic                  Rst_n,
  multi_rate_addr_seq_if.slave  bus
);

  localparam int unsigned       LVL_W = $clog2(LEVELS);
  localparam logic [ADDR_W-1:0] A_MIN = ADDR_W'(ADDR_MIN);
  localparam logic [ADDR_W-1:0] A_MAX = ADDR_W'(ADDR_MAX);
  localparam logic [LVL_W-1:0]  L_TOP = LVL_W'(LEVELS - 1);

  state_e            state_q;
  logic [LVL_W-1:0]  level_q;
  logic [ADDR_W-1:0] addr_q;
  logic              step_q;
  logic              at_end_q;
  logic              flip_q;
  logic              dir_q;

  mode_e             mode_c;
  logic              dir_chg_c;
  logic              flip_eff_c;
  logic              ed_c;
  logic              at_lim_c;
  logic              up_ok_c;
  logic              dn_ok_c;
  logic              speed_req_c;
  logic              clr_c;
  logic              hold_c;
  logic              tick_c;
  logic [ADDR_W-1:0] load_val_c;

  // Decode of controls and per-cycle priority qualifiers.
  always_comb begin
    mode_c      = (bus.mode == 2'b11) ? WRAP : mode_e'(bus.mode);
    dir_chg_c   = (bus.dir != dir_q);
    flip_eff_c  = dir_chg_c ? 1'b0 : flip_q;
    ed_c        = bus.dir ^ flip_eff_c;
    at_lim_c    = ed_c ? (addr_q == A_MIN) : (addr_q == A_MAX);
    up_ok_c     = bus.speed_up && !bus.speed_down && (level_q != L_TOP);
    dn_ok_c     = bus.speed_down && !bus.speed_up && (level_q != '0);
    // Simultaneous up+down leaves the level alone but still restarts the count;
    // a request blocked by saturation is ignored entirely.
    speed_req_c = !bus.load && !bus.pause &&
                  (up_ok_c || dn_ok_c || (bus.speed_up && bus.speed_down));
    clr_c       = bus.load || speed_req_c;
    hold_c      = (state_q == PAUSED) || bus.pause;

    load_val_c = bus.load_addr;
    if (int'(bus.load_addr) < int'(ADDR_MIN)) begin
      load_val_c = A_MIN;
    end else if (int'(bus.load_addr) > int'(ADDR_MAX)) begin
      load_val_c = A_MAX;
    end
  end

  rate_tick_gen #(
    .LEVELS       (LEVELS),
    .DEFAULT_LEVEL(DEFAULT_LEVEL),
    .BASE_PERIOD  (BASE_PERIOD),
    .SHIFT        (SHIFT),
    .LVL_W        (LVL_W)
  ) u_tick (
    .clk   (clk),
    .Rst_n (Rst_n),
    .level (level_q),
    .clear (clr_c),
    .hold  (hold_c),
    .tick_c(tick_c)
  );

  // State, level, address and limit handling.
  always_ff @(posedge clk) begin
    if (!Rst_n) begin
      state_q  <= RUN;
      level_q  <= LVL_W'(DEFAULT_LEVEL);
      addr_q   <= A_MIN;
      step_q   <= 1'b0;
      at_end_q <= 1'b0;
      flip_q   <= 1'b0;
      dir_q    <= 1'b0;
    end else begin
      dir_q  <= bus.dir;
      step_q <= 1'b0;
      if (dir_chg_c) flip_q <= 1'b0;
      if (at_end_q && (dir_chg_c || (mode_c != STOP))) at_end_q <= 1'b0;

      if (bus.load) begin
        addr_q   <= load_val_c;
        at_end_q <= 1'b0;
        flip_q   <= 1'b0;
      end else if (bus.pause) begin
        state_q <= (state_q == RUN) ? PAUSED : RUN;
      end else if (speed_req_c) begin
        if (up_ok_c) level_q <= level_q + LVL_W'(1);
        if (dn_ok_c) level_q <= level_q - LVL_W'(1);
      end else if (tick_c) begin
        if (!at_lim_c) begin
          addr_q <= ed_c ? addr_q - ADDR_W'(1) : addr_q + ADDR_W'(1);
          step_q <= 1'b1;
        end else begin
          case (mode_c)
            STOP: begin
              at_end_q <= 1'b1;
            end
            BOUNCE: begin
              flip_q <= !flip_eff_c;
              addr_q <= ed_c ? A_MIN + ADDR_W'(1) : A_MAX - ADDR_W'(1);
              step_q <= 1'b1;
            end
            default: begin
              addr_q <= ed_c ? A_MAX : A_MIN;
              step_q <= 1'b1;
            end
          endcase
        end
      end
    end
  end

  assign bus.address = addr_q;
  assign bus.step    = step_q;
  assign bus.level   = level_q;
  assign bus.paused  = (state_q == PAUSED);
  assign bus.at_end  = at_end_q;

endmodule

// File: tb/tb_multi_rate_addr_seq.sv
// Bench for multi_rate_addr_seq: directed scenarios followed by random
// control traffic, scored against a behavioural model through queues.
module tb_multi_rate_addr_seq;

  localparam int AW   = 4;
  localparam int LV   = 4;
  localparam int DEF  = 1;
  localparam int BASE = 8;
  localparam int SH   = 1;
  localparam int AMIN = 0;
  localparam int AMAX = 15;
  localparam int LW   = 2;

  logic clk   = 1'b0;
  logic Rst_n = 1'b0;
  always #5 clk = ~clk;

  multi_rate_addr_seq_if #(.ADDR_W(AW), .LVL_W(LW)) bus();

  multi_rate_addr_seq #(
    .ADDR_W(AW), .LEVELS(LV), .DEFAULT_LEVEL(DEF), .BASE_PERIOD(BASE),
    .SHIFT(SH), .ADDR_MIN(AMIN), .ADDR_MAX(AMAX)
  ) dut (
    .clk  (clk),
    .Rst_n(Rst_n),
    .bus  (bus)
  );

  typedef struct {
    int cyc;
    bit step;
    int addr;
    int lvl;
    bit paused;
    bit at_end;
  } exp_t;

  exp_t st_q[$];
  int   step_q[$];
  int   n_total = 0;
  int   n_bad   = 0;
  int   drv_cyc = 0;

  // Reference model state.
  int m_addr, m_lvl, m_cnt;
  bit m_paused, m_flip, m_atend, m_dirprev;

  bit       cur_dir  = 1'b0;
  bit [1:0] cur_mode = 2'b00;

  function automatic int period(input int l);
    int p;
    if (l <= DEF) return BASE * (2 ** (SH * (DEF - l)));
    p = BASE / (2 ** (SH * (l - DEF)));
    return (p < 1) ? 1 : p;
  endfunction

  // One clock edge of the sequencer, as described behaviourally.
  task automatic model_edge(input bit rst_n, input bit up, input bit dn, input bit pz,
                            input bit d, input bit [1:0] md, input bit ld,
                            input int la, output bit st);
    int  delta, nxt, rng;
    bit  lvl_req;
    st = 1'b0;
    if (!rst_n) begin
      m_addr = AMIN; m_lvl = DEF; m_cnt = 0;
      m_paused = 0; m_flip = 0; m_atend = 0; m_dirprev = 0;
      return;
    end
    if (d != m_dirprev) begin m_flip = 0; m_atend = 0; end
    if (md != 2'd1) m_atend = 0;
    m_dirprev = d;
    lvl_req = (up && dn) || (up && m_lvl < LV - 1) || (dn && m_lvl > 0);
    if (ld) begin
      m_addr = (la < AMIN) ? AMIN : (la > AMAX) ? AMAX : la;
      m_cnt = 0; m_atend = 0; m_flip = 0;
    end else if (pz) begin
      m_paused = !m_paused;
    end else if (lvl_req) begin
      if (!(up && dn)) m_lvl = up ? m_lvl + 1 : m_lvl - 1;
      m_cnt = 0;
    end else if (!m_paused) begin
      if (m_cnt + 1 == period(m_lvl)) begin
        m_cnt = 0;
        delta = (d ^ m_flip) ? -1 : 1;
        nxt   = m_addr + delta;
        rng   = AMAX - AMIN + 1;
        if (nxt >= AMIN && nxt <= AMAX) begin
          m_addr = nxt; st = 1;
        end else if (md == 2'd1) begin
          m_atend = 1;
        end else if (md == 2'd2) begin
          m_flip = !m_flip; m_addr = m_addr - delta; st = 1;
        end else begin
          m_addr = AMIN + ((nxt - AMIN + rng) % rng); st = 1;
        end
      end else begin
        m_cnt++;
      end
    end
  endtask

  // Apply one cycle of inputs, predict the result, and wait past the edge.
  task automatic drive_cycle(input bit rst_n, input bit up, input bit dn, input bit pz,
                             input bit ld, input int la);
    bit   st;
    exp_t e;
    @(negedge clk);
    Rst_n          = rst_n;
    bus.speed_up   = up;
    bus.speed_down = dn;
    bus.pause      = pz;
    bus.dir        = cur_dir;
    bus.mode       = cur_mode;
    bus.load       = ld;
    bus.load_addr  = AW'(la);
    model_edge(rst_n, up, dn, pz, cur_dir, cur_mode, ld, la, st);
    drv_cyc++;
    e = '{drv_cyc, st, m_addr, m_lvl, m_paused, m_atend};
    st_q.push_back(e);
    if (st) step_q.push_back(m_addr);
    @(posedge clk);
    #1;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) drive_cycle(1, 0, 0, 0, 0, 0);
  endtask

  task automatic chk(input string nm, input int got, input int want);
    n_total++;
    if (got != want) begin
      n_bad++;
      $display("FAIL %s got=%0d want=%0d", nm, got, want);
    end
  endtask

  // Monitor: every driven edge has a status record; every step has an address.
  exp_t mon_e;
  int   mon_a;
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (st_q.size() != 0) begin
        mon_e = st_q.pop_front();
        n_total++;
        if (bus.step !== mon_e.step || int'(bus.address) != mon_e.addr ||
            int'(bus.level) != mon_e.lvl || bus.paused !== mon_e.paused ||
            bus.at_end !== mon_e.at_end) begin
          n_bad++;
          $display("FAIL status cyc=%0d got step=%0b addr=%0d lvl=%0d paused=%0b at_end=%0b want step=%0b addr=%0d lvl=%0d paused=%0b at_end=%0b",
                   mon_e.cyc, bus.step, bus.address, bus.level, bus.paused, bus.at_end,
                   mon_e.step, mon_e.addr, mon_e.lvl, mon_e.paused, mon_e.at_end);
        end
        if (bus.step === 1'b1) begin
          n_total++;
          if (step_q.size() == 0) begin
            n_bad++;
            $display("FAIL step_unexpected cyc=%0d got addr=%0d want no step", mon_e.cyc, bus.address);
          end else begin
            mon_a = step_q.pop_front();
            if (int'(bus.address) != mon_a) begin
              n_bad++;
              $display("FAIL step_addr cyc=%0d got=%0d want=%0d", mon_e.cyc, bus.address, mon_a);
            end
          end
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int r;
    bit up, dn, pz, ld, rs;
    bus.speed_up = 0; bus.speed_down = 0; bus.pause = 0; bus.dir = 0;
    bus.mode = 0; bus.load = 0; bus.load_addr = '0;

    drive_cycle(0, 0, 0, 0, 0, 0);
    drive_cycle(0, 0, 0, 0, 0, 0);
    chk("reset_addr", int'(bus.address), 0);
    chk("reset_level", int'(bus.level), 1);
    chk("reset_paused", int'(bus.paused), 0);
    chk("reset_at_end", int'(bus.at_end), 0);

    run(40);
    chk("run40_addr", int'(bus.address), 5);

    // Wrap at both ends.
    drive_cycle(1, 0, 0, 0, 1, 15);
    run(8);
    chk("wrap_up", int'(bus.address), 0);
    cur_dir = 1;
    run(8);
    chk("wrap_down", int'(bus.address), 15);

    // Level saturation and simultaneous requests.
    for (int i = 0; i < 3; i++) drive_cycle(1, 1, 0, 0, 0, 0);
    chk("level_top", int'(bus.level), 3);
    run(9);
    for (int i = 0; i < 4; i++) drive_cycle(1, 0, 1, 0, 0, 0);
    chk("level_bottom", int'(bus.level), 0);
    run(5);
    drive_cycle(1, 1, 1, 0, 0, 0);
    chk("level_both", int'(bus.level), 0);
    run(20);
    drive_cycle(1, 1, 0, 0, 0, 0);

    // Pause at cnt=5 and resume.
    run(5);
    drive_cycle(1, 0, 0, 1, 0, 0);
    chk("paused_set", int'(bus.paused), 1);
    run(100);
    drive_cycle(1, 0, 0, 1, 0, 0);
    chk("paused_clr", int'(bus.paused), 0);
    run(6);

    // Stop mode.
    cur_mode = 2'd1; cur_dir = 0;
    drive_cycle(1, 0, 0, 0, 1, 14);
    run(8);
    chk("stop_reach", int'(bus.address), 15);
    run(16);
    chk("stop_at_end", int'(bus.at_end), 1);
    chk("stop_hold", int'(bus.address), 15);
    cur_dir = 1;
    run(1);
    chk("stop_release", int'(bus.at_end), 0);
    run(7);
    chk("stop_back", int'(bus.address), 14);

    // Bounce mode at both limits.
    cur_mode = 2'd2; cur_dir = 0;
    drive_cycle(1, 0, 0, 0, 1, 14);
    run(24);
    chk("bounce_top", int'(bus.address), 13);
    cur_dir = 1;
    drive_cycle(1, 0, 0, 0, 1, 1);
    run(24);
    chk("bounce_bottom", int'(bus.address), 2);

    // Load coinciding with a tick.
    cur_mode = 2'd0; cur_dir = 0;
    drive_cycle(1, 0, 0, 0, 1, 5);
    run(7);
    drive_cycle(1, 0, 0, 0, 1, 9);
    chk("load_wins_addr", int'(bus.address), 9);
    chk("load_wins_step", int'(bus.step), 0);
    run(8);

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      r  = $urandom_range(0, 99);
      up = (r < 3) || (r == 10);
      dn = (r >= 3 && r < 6) || (r == 10);
      pz = (r == 6 || r == 7);
      ld = (r == 8 || r == 9);
      rs = (r == 11) && ($urandom_range(0, 9) == 0);
      if ($urandom_range(0, 49) == 0) cur_dir = ~cur_dir;
      if ($urandom_range(0, 79) == 0) cur_mode = 2'($urandom_range(0, 3));
      drive_cycle(!rs, up, dn, pz, ld, int'($urandom_range(0, 15)));
    end

    @(negedge clk);
    @(negedge clk);
    chk("queue_drain", st_q.size() + step_q.size(), 0);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
